// File: rtl/pc_gen_pkg.sv
// Shared defines for the fetch front end:
// state encoding, reset/step defaults and common constants.
package pc_gen_pkg;

  localparam logic        EN        = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0;

  localparam logic [31:0] PC_RESET_VEC  = 32'h0;
  localparam int          PC_INST_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RUN        = 2'd1,
    S_HOLD_REDIR = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request / redirect bundle between the
// pipeline control side and the pc generator.
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6,
  parameter int N_REDIR = 2
);

  logic [STALL_W-1:0]        stall;
  logic [N_REDIR-1:0]        redir_valid;
  logic [N_REDIR*ADDR_W-1:0] redir_addr;
  logic                      fetch_ready;
  logic                      fetch_valid;
  logic [ADDR_W-1:0]         fetch_addr;
  logic [ADDR_W-1:0]         pc;
  logic                      ce;
  logic                      flush;
  logic                      misalign;

  modport master (
    output stall, redir_valid, redir_addr,
    output fetch_ready,
    input  fetch_valid, fetch_addr, pc,
    input  ce, flush, misalign
  );

  modport slave (
    input  stall, redir_valid, redir_addr,
    input  fetch_ready,
    output fetch_valid, fetch_addr, pc,
    output ce, flush, misalign
  );

endinterface

// File: rtl/pc_gen_redir_arb.sv
// Fixed-priority redirect picker; channel 0 wins.
// Purely combinational.
module redir_arb #(
  parameter int N_REDIR = 2,
  parameter int ADDR_W  = 32
) (
  input  logic [N_REDIR-1:0]        valid,
  input  logic [N_REDIR*ADDR_W-1:0] addr,
  output logic                      hit,
  output logic [ADDR_W-1:0]         sel
);

  // Walk high to low so the lowest hit is the last write.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = N_REDIR - 1; k >= 0; k--) begin
      if (valid[k]) begin
        hit = 1'b1;
        sel = addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator with a held fetch
// request and deferred redirect capture.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR =
    ADDR_W'(PC_RESET_VEC),
  parameter int INST_BYTES = PC_INST_BYTES,
  parameter int STALL_W    = 6,
  parameter int N_REDIR    = 2
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  localparam logic [ADDR_W-1:0] LOW_MASK =
    ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(INST_BYTES);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_mis_q, pend_mis_d;
  logic              held_q, held_d;
  logic              ce_q, ce_d;
  logic              flush_q, flush_d;
  logic              mis_q, mis_d;

  logic              hit;
  logic [ADDR_W-1:0] sel;
  logic [ADDR_W-1:0] tgt;
  logic              tgt_mis;
  logic              fv;
  logic              hs;
  logic              wait_w;
  logic              unused_stall;

  redir_arb #(
    .N_REDIR (N_REDIR),
    .ADDR_W  (ADDR_W)
  ) u_arb (
    .valid (bus.redir_valid),
    .addr  (bus.redir_addr),
    .hit   (hit),
    .sel   (sel)
  );

  assign tgt     = sel & ~LOW_MASK;
  assign tgt_mis = |(sel & LOW_MASK);

  // A held request stays valid even if stall rises.
  assign fv = (state_q != S_IDLE) &&
              (!bus.stall[0] || held_q);
  assign hs     = fv && bus.fetch_ready;
  assign wait_w = fv && !bus.fetch_ready;

  assign unused_stall = ^bus.stall;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    pend_mis_d  = pend_mis_q;
    held_d      = held_q;
    ce_d        = ce_q;
    flush_d     = 1'b0;
    mis_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_RUN;
        ce_d    = EN;
      end
      S_RUN: begin
        held_d = wait_w;
        if (hit && !wait_w) begin
          pc_d    = tgt;
          flush_d = 1'b1;
          mis_d   = tgt_mis;
        end else if (hit) begin
          pend_addr_d = tgt;
          pend_mis_d  = tgt_mis;
          state_d     = S_HOLD_REDIR;
        end else if (hs) begin
          pc_d = pc_q + STEP;
        end
      end
      S_HOLD_REDIR: begin
        held_d = wait_w;
        if (hs) begin
          state_d     = S_RUN;
          flush_d     = 1'b1;
          pend_addr_d = ZERO_WORD[ADDR_W-1:0];
          pend_mis_d  = 1'b0;
          if (hit) begin
            pc_d  = tgt;
            mis_d = tgt_mis;
          end else begin
            pc_d  = pend_addr_q;
            mis_d = pend_mis_q;
          end
        end else if (hit) begin
          pend_addr_d = tgt;
          pend_mis_d  = tgt_mis;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_VECTOR;
      pend_addr_q <= ZERO_WORD[ADDR_W-1:0];
      pend_mis_q  <= 1'b0;
      held_q      <= 1'b0;
      ce_q        <= 1'b0;
      flush_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      pend_mis_q  <= pend_mis_d;
      held_q      <= held_d;
      ce_q        <= ce_d;
      flush_q     <= flush_d;
      mis_q       <= mis_d;
    end
  end

  assign bus.fetch_valid = fv;
  assign bus.fetch_addr  = pc_q;
  assign bus.pc          = pc_q;
  assign bus.ce          = ce_q;
  assign bus.flush       = flush_q;
  assign bus.misalign    = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 32-bit instance
// plus an 8-bit instance for the wrap case.
module tb_pc_gen;

  logic clk;
  logic rst;
  int   errs;
  int   checks;

  pc_gen_if #(
    .ADDR_W(32), .STALL_W(6), .N_REDIR(2)
  ) bus_a ();
  pc_gen_if #(
    .ADDR_W(8), .STALL_W(6), .N_REDIR(2)
  ) bus_b ();

  pc_gen #(
    .ADDR_W(32), .RESET_VECTOR(32'h0),
    .INST_BYTES(4), .STALL_W(6), .N_REDIR(2)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pc_gen #(
    .ADDR_W(8), .RESET_VECTOR(8'h0),
    .INST_BYTES(4), .STALL_W(6), .N_REDIR(2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir_a(
    input logic [1:0]  v,
    input logic [31:0] a0,
    input logic [31:0] a1
  );
    bus_a.redir_valid = v;
    bus_a.redir_addr  = {a1, a0};
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst    = 1'b1;
    bus_a.stall       = '0;
    bus_a.redir_valid = '0;
    bus_a.redir_addr  = '0;
    bus_a.fetch_ready = 1'b1;
    bus_b.stall       = '0;
    bus_b.redir_valid = '0;
    bus_b.redir_addr  = '0;
    bus_b.fetch_ready = 1'b1;
    tick();
    tick();
    chk("rst_pc", bus_a.pc, 32'h0);
    chk("rst_ce", {31'b0, bus_a.ce}, 32'h0);
    chk("rst_fv", {31'b0, bus_a.fetch_valid}, 32'h0);
    chk("rst_flush", {31'b0, bus_a.flush}, 32'h0);

    // first cycle after release: IDLE, redirect ignored
    rst = 1'b0;
    redir_a(2'b01, 32'h300, 32'h0);
    #1;
    chk("idle_ce", {31'b0, bus_a.ce}, 32'h0);
    chk("idle_pc", bus_a.pc, 32'h0);
    chk("idle_fv", {31'b0, bus_a.fetch_valid}, 32'h0);
    tick();
    redir_a(2'b00, 32'h0, 32'h0);
    chk("run_ce", {31'b0, bus_a.ce}, 32'h1);
    chk("idle_redir_ign", bus_a.fetch_addr, 32'h0);
    chk("idle_no_flush", {31'b0, bus_a.flush}, 32'h0);
    chk("run_fv", {31'b0, bus_a.fetch_valid}, 32'h1);
    chk("b_start", {24'b0, bus_b.pc}, 32'h0);
    bus_b.redir_valid = 2'b01;
    bus_b.redir_addr  = {8'h00, 8'hFC};
    tick();
    bus_b.redir_valid = 2'b00;
    chk("seq_4", bus_a.fetch_addr, 32'h4);
    chk("b_fc", {24'b0, bus_b.pc}, 32'hFC);
    tick();
    chk("seq_8", bus_a.fetch_addr, 32'h8);
    chk("b_wrap", {24'b0, bus_b.pc}, 32'h0);
    tick();
    chk("seq_c", bus_a.fetch_addr, 32'hC);
    tick();
    chk("seq_10", bus_a.fetch_addr, 32'h10);

    // backpressure with a deferred ch1 redirect
    bus_a.fetch_ready = 1'b0;
    tick();
    chk("bp1_addr", bus_a.fetch_addr, 32'h10);
    redir_a(2'b10, 32'h0, 32'h80);
    tick();
    redir_a(2'b00, 32'h0, 32'h0);
    chk("bp2_addr", bus_a.fetch_addr, 32'h10);
    chk("bp2_flush", {31'b0, bus_a.flush}, 32'h0);
    tick();
    chk("bp3_addr", bus_a.fetch_addr, 32'h10);
    chk("bp3_fv", {31'b0, bus_a.fetch_valid}, 32'h1);
    bus_a.fetch_ready = 1'b1;
    tick();
    chk("hold_pc", bus_a.pc, 32'h80);
    chk("hold_flush", {31'b0, bus_a.flush}, 32'h1);
    tick();
    chk("hold_flush_end", {31'b0, bus_a.flush}, 32'h0);
    chk("hold_next", bus_a.pc, 32'h84);

    // both channels during handshake: ch0 wins
    redir_a(2'b11, 32'h100, 32'h200);
    tick();
    chk("prio_pc", bus_a.pc, 32'h100);
    chk("prio_flush", {31'b0, bus_a.flush}, 32'h1);
    chk("prio_mis", {31'b0, bus_a.misalign}, 32'h0);

    // misaligned target is rounded down
    redir_a(2'b01, 32'h103, 32'h0);
    tick();
    redir_a(2'b00, 32'h0, 32'h0);
    chk("mis_pc", bus_a.pc, 32'h100);
    chk("mis_pulse", {31'b0, bus_a.misalign}, 32'h1);
    tick();
    chk("mis_end", {31'b0, bus_a.misalign}, 32'h0);
    chk("mis_next", bus_a.pc, 32'h104);

    // stall with nothing outstanding
    redir_a(2'b01, 32'h20, 32'h0);
    tick();
    redir_a(2'b00, 32'h0, 32'h0);
    chk("stall_pc0", bus_a.pc, 32'h20);
    bus_a.stall = 6'b000001;
    #1;
    chk("stall_fv0", {31'b0, bus_a.fetch_valid}, 32'h0);
    tick();
    chk("stall_pc1", bus_a.pc, 32'h20);
    chk("stall_fv1", {31'b0, bus_a.fetch_valid}, 32'h0);
    tick();
    chk("stall_pc2", bus_a.pc, 32'h20);
    bus_a.stall = 6'b0;
    #1;
    chk("unstall_fv", {31'b0, bus_a.fetch_valid}, 32'h1);
    chk("unstall_addr", bus_a.fetch_addr, 32'h20);
    tick();
    chk("unstall_next", bus_a.pc, 32'h24);

    // a held request survives a late stall
    bus_a.fetch_ready = 1'b0;
    tick();
    bus_a.stall = 6'b000001;
    #1;
    chk("held_fv", {31'b0, bus_a.fetch_valid}, 32'h1);
    chk("held_addr", bus_a.fetch_addr, 32'h24);
    bus_a.fetch_ready = 1'b1;
    tick();
    chk("held_done_pc", bus_a.pc, 32'h28);
    chk("held_done_fv", {31'b0, bus_a.fetch_valid}, 32'h0);
    bus_a.stall = 6'b0;

    // reset while in HOLD_REDIR
    bus_a.fetch_ready = 1'b0;
    tick();
    redir_a(2'b01, 32'h300, 32'h0);
    tick();
    redir_a(2'b00, 32'h0, 32'h0);
    chk("pre_rst_addr", bus_a.fetch_addr, 32'h28);
    rst = 1'b1;
    bus_a.fetch_ready = 1'b1;
    tick();
    chk("hrst_pc", bus_a.pc, 32'h0);
    chk("hrst_flush", {31'b0, bus_a.flush}, 32'h0);
    chk("hrst_fv", {31'b0, bus_a.fetch_valid}, 32'h0);
    rst = 1'b0;
    tick();
    chk("hrst_run_pc", bus_a.pc, 32'h0);
    chk("hrst_run_flush", {31'b0, bus_a.flush}, 32'h0);
    tick();
    chk("hrst_seq", bus_a.pc, 32'h4);
    chk("hrst_seq_flush", {31'b0, bus_a.flush}, 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
